// File: rtl/note_sequencer.sv
// note_sequencer: records timed note events and plays them back to the piano amplifier
// Ports:
//   clk, rst       system clock, asynchronous active-high reset
//   note_switches  debounced keys, bit6=C .. bit0=B
//   toggle_pb      rising edge starts or stops playback
//   inc_octave     rising edge raises octave_sel (saturating at OCT_MAX)
//   dec_octave     rising edge lowers octave_sel (saturating at OCT_MIN)
//   loop_en        restart playback from entry 0 after the last entry
//   clear          empties the recording (ignored during playback)
//   octave_sel     currently selected octave
//   octave_out     octave to the amplifier
//   note_out       note to the amplifier, 0=silent, 1..7=C..B
//   pb_active      high while playing back
//   rec_count      number of stored events
//   full           rec_count == DEPTH
module note_sequencer #(
    parameter int DEPTH    = 256,
    parameter int ADDR_W   = 8,
    parameter int DUR_W    = 12,
    parameter int TICK_DIV = 250000,
    parameter int OCT_MIN  = 1,
    parameter int OCT_MAX  = 7,
    parameter int OCT_INIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [6:0]        note_switches,
    input  logic              toggle_pb,
    input  logic              inc_octave,
    input  logic              dec_octave,
    input  logic              loop_en,
    input  logic              clear,
    output logic [2:0]        octave_sel,
    output logic [2:0]        octave_out,
    output logic [2:0]        note_out,
    output logic              pb_active,
    output logic [ADDR_W:0]   rec_count,
    output logic              full
);
    typedef enum logic [2:0] {IDLE, REC, PB_LOAD, PB_WAIT, PB_HOLD} state_t;
    localparam int ENT_W = DUR_W + 6;
    localparam int CNT_W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam logic [DUR_W-1:0] DUR_MAX = '1;

    state_t            state, state_n;
    logic              toggle_q, inc_q, dec_q;
    logic              toggle_e, inc_e, dec_e;
    logic [2:0]        key, octave_sel_n, octave_out_n, note_out_n;
    logic [2:0]        cur_oct, cur_oct_n, cur_note, cur_note_n;
    logic              pb_active_n;
    logic [ADDR_W:0]   rec_count_n;
    logic [ADDR_W-1:0] idx, idx_n;
    logic [DUR_W-1:0]  dur, dur_n, dur_inc, hold, hold_n;
    logic [CNT_W-1:0]  cnt;
    logic              tick, restart, we;
    logic [ENT_W-1:0]  mem [DEPTH];
    logic [ENT_W-1:0]  rd_data, wdata;

    assign toggle_e = toggle_pb & ~toggle_q;
    assign inc_e    = inc_octave & ~inc_q;
    assign dec_e    = dec_octave & ~dec_q;
    assign tick     = cnt == CNT_W'(TICK_DIV - 1);
    assign full     = rec_count == (ADDR_W+1)'(DEPTH);
    // The tick landing on the closing edge still belongs to the event being closed
    assign dur_inc  = (tick && dur != DUR_MAX) ? dur + DUR_W'(1) : dur;
    assign wdata    = {cur_oct, cur_note, dur_inc == '0 ? DUR_W'(1) : dur_inc};

    assign octave_sel_n = (inc_e && !dec_e && octave_sel < 3'(OCT_MAX)) ? octave_sel + 3'd1 :
                          (dec_e && !inc_e && octave_sel > 3'(OCT_MIN)) ? octave_sel - 3'd1 : octave_sel;

    // Only a single pressed key is a note; none or several keys is a rest
    always_comb begin
        key = '0;
        for (int i = 0; i < 7; i++)
            if (note_switches == 7'(64 >> i)) key = 3'(i + 1);
    end

    always_comb begin
        state_n      = state;
        octave_out_n = octave_out;
        note_out_n   = note_out;
        pb_active_n  = pb_active;
        rec_count_n  = rec_count;
        idx_n        = idx;
        cur_oct_n    = cur_oct;
        cur_note_n   = cur_note;
        dur_n        = dur;
        hold_n       = hold;
        restart      = 1'b0;
        we           = 1'b0;
        case (state)
            IDLE, REC: begin
                note_out_n   = key;
                octave_out_n = octave_sel;
                if (state == REC) dur_n = dur_inc;
                if (clear) begin
                    rec_count_n = '0;
                    state_n     = IDLE;
                end else if (toggle_e) begin
                    we          = state == REC && cur_note != '0 && !full;
                    rec_count_n = rec_count + (ADDR_W+1)'(we);
                    state_n     = IDLE;
                    if (rec_count != '0 || we) begin
                        idx_n       = '0;
                        pb_active_n = 1'b1;
                        state_n     = PB_LOAD;
                    end
                end else if (state == IDLE ? key != '0 : key != cur_note) begin
                    we          = state == REC && !full;
                    rec_count_n = rec_count + (ADDR_W+1)'(we);
                    cur_oct_n   = octave_sel;
                    cur_note_n  = key;
                    dur_n       = '0;
                    restart     = 1'b1;
                    state_n     = REC;
                end
            end
            PB_LOAD: state_n = PB_WAIT;
            PB_WAIT: begin
                octave_out_n = rd_data[ENT_W-1 -: 3];
                note_out_n   = rd_data[DUR_W+2 -: 3];
                hold_n       = rd_data[DUR_W-1:0];
                restart      = 1'b1;
                state_n      = PB_HOLD;
            end
            PB_HOLD: begin
                if (tick && hold <= DUR_W'(1)) begin
                    state_n = PB_LOAD;
                    if ((ADDR_W+1)'(idx) + (ADDR_W+1)'(1) < rec_count) idx_n = idx + ADDR_W'(1);
                    else if (loop_en) idx_n = '0;
                    else begin
                        pb_active_n = 1'b0;
                        note_out_n  = '0;
                        state_n     = IDLE;
                    end
                end else if (tick) hold_n = hold - DUR_W'(1);
            end
            default: state_n = IDLE;
        endcase
        if (toggle_e && state != IDLE && state != REC) begin
            pb_active_n = 1'b0;
            note_out_n  = '0;
            state_n     = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            toggle_q   <= 1'b0;
            inc_q      <= 1'b0;
            dec_q      <= 1'b0;
            octave_sel <= 3'(OCT_INIT);
            octave_out <= '0;
            note_out   <= '0;
            pb_active  <= 1'b0;
            rec_count  <= '0;
            idx        <= '0;
            cur_oct    <= '0;
            cur_note   <= '0;
            dur        <= '0;
            hold       <= '0;
            cnt        <= '0;
        end else begin
            state      <= state_n;
            toggle_q   <= toggle_pb;
            inc_q      <= inc_octave;
            dec_q      <= dec_octave;
            octave_sel <= octave_sel_n;
            octave_out <= octave_out_n;
            note_out   <= note_out_n;
            pb_active  <= pb_active_n;
            rec_count  <= rec_count_n;
            idx        <= idx_n;
            cur_oct    <= cur_oct_n;
            cur_note   <= cur_note_n;
            dur        <= dur_n;
            hold       <= hold_n;
            cnt        <= (restart || tick) ? '0 : cnt + CNT_W'(1);
        end
    end

    // Event buffer: contents survive reset, only rec_count marks what is valid
    always_ff @(posedge clk) begin
        if (we) mem[rec_count[ADDR_W-1:0]] <= wdata;
        rd_data <= mem[idx];
    end
endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: directed and randomized checks of note_sequencer against an event-level model
module tb_note_sequencer;
    localparam int DEPTH = 4, ADDR_W = 2, DUR_W = 4, TD = 4, DMAX = 15;

    logic              clk = 1'b0, rst = 1'b0;
    logic [6:0]        note_switches = '0;
    logic              toggle_pb = 1'b0, inc_octave = 1'b0, dec_octave = 1'b0;
    logic              loop_en = 1'b0, clear = 1'b0;
    logic [2:0]        octave_sel, octave_out, note_out;
    logic              pb_active, full;
    logic [ADDR_W:0]   rec_count;

    note_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DUR_W(DUR_W), .TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst), .note_switches(note_switches), .toggle_pb(toggle_pb),
        .inc_octave(inc_octave), .dec_octave(dec_octave), .loop_en(loop_en), .clear(clear),
        .octave_sel(octave_sel), .octave_out(octave_out), .note_out(note_out),
        .pb_active(pb_active), .rec_count(rec_count), .full(full)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    bit chk_on = 1'b0;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: mode 0 idle, 1 recording, 2 playing. Durations come from elapsed cycles.
    int m_sel, m_oct, m_note, m_pb, m_cnt, m_mode;
    int cur_oct, cur_note, len, p_idx, p_gap, p_hold;
    bit p_tg, p_in, p_de;
    int e_oct[DEPTH], e_note[DEPTH], e_dur[DEPTH];

    function automatic int decode(logic [6:0] k);
        if ($countones(k) != 1) return 0;
        for (int i = 0; i < 7; i++) if (k[6-i]) return i + 1;
        return 0;
    endfunction

    task automatic push();
        int d;
        if (m_cnt >= DEPTH) return;
        d = len / TD;
        if (d > DMAX) d = DMAX;
        if (d < 1) d = 1;
        e_oct[m_cnt] = cur_oct; e_note[m_cnt] = cur_note; e_dur[m_cnt] = d;
        m_cnt++;
    endtask

    task automatic model_step();
        int k, ns;
        bit te, ie, de;
        if (rst) begin
            m_sel = 4; m_oct = 0; m_note = 0; m_pb = 0; m_cnt = 0; m_mode = 0;
            p_tg = 0; p_in = 0; p_de = 0;
            return;
        end
        k  = decode(note_switches);
        te = toggle_pb && !p_tg;
        ie = inc_octave && !p_in;
        de = dec_octave && !p_de;
        ns = m_sel;
        if (ie && !de && m_sel < 7) ns = m_sel + 1;
        else if (de && !ie && m_sel > 1) ns = m_sel - 1;
        if (m_mode != 2) begin
            m_note = k; m_oct = m_sel;
            if (m_mode == 1) len++;
            if (clear) begin
                m_cnt = 0; m_mode = 0;
            end else if (te) begin
                if (m_mode == 1 && cur_note != 0) push();
                m_mode = 0;
                if (m_cnt > 0) begin m_mode = 2; m_pb = 1; p_idx = 0; p_gap = 2; end
            end else if (m_mode == 0 ? k != 0 : k != cur_note) begin
                if (m_mode == 1) push();
                cur_oct = m_sel; cur_note = k; len = 0; m_mode = 1;
            end
        end else if (te) begin
            m_mode = 0; m_pb = 0; m_note = 0;
        end else if (p_gap > 0) begin
            p_gap--;
            if (p_gap == 0) begin
                m_note = e_note[p_idx]; m_oct = e_oct[p_idx]; p_hold = e_dur[p_idx] * TD;
            end
        end else begin
            p_hold--;
            if (p_hold == 0) begin
                if (p_idx + 1 < m_cnt) begin p_idx++; p_gap = 2; end
                else if (loop_en) begin p_idx = 0; p_gap = 2; end
                else begin m_mode = 0; m_pb = 0; m_note = 0; end
            end
        end
        m_sel = ns; p_tg = toggle_pb; p_in = inc_octave; p_de = dec_octave;
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        #1;
        if (chk_on) begin
            chk("octave_sel", octave_sel, m_sel);
            chk("octave_out", octave_out, m_oct);
            chk("note_out", note_out, m_note);
            chk("pb_active", pb_active, m_pb);
            chk("rec_count", rec_count, m_cnt);
            chk("full", full, m_cnt == DEPTH);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1; note_switches = 0; toggle_pb = 0; inc_octave = 0; dec_octave = 0;
        loop_en = 0; clear = 0;
        @(negedge clk);
        rst = 0;
    endtask

    task automatic press(logic [6:0] k, int n);
        note_switches = k;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_oct(bit up);
        if (up) inc_octave = 1; else dec_octave = 1;
        @(negedge clk);
        inc_octave = 0; dec_octave = 0;
        @(negedge clk);
    endtask

    // Releases keys, raises toggle_pb and counts playback samples until pb_active drops
    task automatic play(output int pb, output int n1, output int n3);
        pb = 0; n1 = 0; n3 = 0;
        note_switches = 0; toggle_pb = 1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            toggle_pb = 0;
            if (!pb_active) break;
            pb++;
            if (note_out == 1) n1++;
            if (note_out == 3) n3++;
        end
        chk("pb_end_active", pb_active, 0);
        chk("pb_end_note", note_out, 0);
    endtask

    int pb, n1, n3, starts, prev, r;

    initial begin
        #1 rst = 1;
        @(negedge clk);
        @(negedge clk);
        rst = 0; chk_on = 1;
        chk("rst_octave_sel", octave_sel, 4);
        chk("rst_note_out", note_out, 0);
        chk("rst_rec_count", rec_count, 0);
        chk("rst_full", full, 0);
        repeat (4) pulse_oct(1);
        chk("oct_sat_high", octave_sel, 7);
        repeat (7) pulse_oct(0);
        chk("oct_sat_low", octave_sel, 1);

        do_reset();
        press(7'b1000000, 8); press(7'b0000000, 4); press(7'b0010000, 12);
        play(pb, n1, n3);
        chk("rec3_count", rec_count, 3);
        chk("rec3_pb_cycles", pb, 30);
        chk("rec3_c_cycles", n1, 10);
        chk("rec3_e_cycles", n3, 12);

        do_reset();
        for (int i = 0; i < 6; i++) press(7'(64 >> i), 4);
        play(pb, n1, n3);
        chk("full_count", rec_count, 4);
        chk("full_flag", full, 1);
        chk("full_pb_cycles", pb, 24);

        do_reset();
        loop_en = 1;
        press(7'b1000000, 4); press(7'b0100000, 4);
        note_switches = 0; toggle_pb = 1;
        starts = 0; prev = 0;
        repeat (30) begin
            @(negedge clk);
            toggle_pb = 0;
            if (note_out == 1 && prev != 1) starts++;
            prev = note_out;
        end
        chk("loop_active", pb_active, 1);
        chk("loop_repeats", starts >= 2, 1);
        toggle_pb = 1;
        @(negedge clk);
        toggle_pb = 0;
        chk("stop_note", note_out, 0);
        chk("stop_pb", pb_active, 0);
        loop_en = 0;

        do_reset();
        press(7'b1000000, 8); press(7'b1100000, 4); press(7'b0010000, 4);
        play(pb, n1, n3);
        chk("rest_count", rec_count, 3);
        chk("rest_pb_cycles", pb, 22);
        chk("rest_c_cycles", n1, 10);
        chk("rest_e_cycles", n3, 4);

        do_reset();
        press(7'b1000000, 80);
        play(pb, n1, n3);
        chk("sat_pb_cycles", pb, 62);
        chk("sat_c_cycles", n1, 60);

        do_reset();
        press(7'b1000000, 8);
        note_switches = 0; toggle_pb = 1;
        repeat (6) begin @(negedge clk); toggle_pb = 0; end
        rst = 1;
        #1;
        chk("rst_pb_note", note_out, 0);
        chk("rst_pb_octave_out", octave_out, 0);
        chk("rst_pb_active", pb_active, 0);
        chk("rst_pb_count", rec_count, 0);
        chk("rst_pb_octave_sel", octave_sel, 4);
        @(negedge clk);
        rst = 0;

        do_reset();
        press(7'b1000000, 4); press(7'b0100000, 4);
        note_switches = 0; clear = 1; toggle_pb = 1;
        @(negedge clk);
        clear = 0; toggle_pb = 0;
        chk("clr_tg_count", rec_count, 0);
        chk("clr_tg_pb", pb_active, 0);
        @(negedge clk);
        chk("clr_tg_pb_later", pb_active, 0);

        do_reset();
        for (int c = 0; c < 4000; c++) begin
            r = $urandom_range(0, 99);
            if (r < 8) note_switches = 7'(64 >> $urandom_range(0, 6));
            else if (r < 11) note_switches = 0;
            else if (r < 12) note_switches = 7'($urandom);
            if ($urandom_range(0, 39) == 0) toggle_pb = ~toggle_pb;
            inc_octave = $urandom_range(0, 9) == 0;
            dec_octave = $urandom_range(0, 9) == 0;
            clear = $urandom_range(0, 149) == 0;
            if ($urandom_range(0, 99) == 0) loop_en = ~loop_en;
            @(negedge clk);
        end
        note_switches = 0; toggle_pb = 0; inc_octave = 0; dec_octave = 0; clear = 0; loop_en = 0;
        repeat (3) @(negedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
